// File: rtl/control_sequencer_if.sv
// Bundle between the micro-step control sequencer and the datapath it steers.
// The master modport is the sequencer; the slave modport is the datapath.
interface control_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] i_IR_DATA;
  logic                  i_CARRY;
  logic                  i_ZERO;

  logic                  o_PC_WRITE_BUS;
  logic                  o_PC_COUNT_ENABLE;
  logic                  o_OUT_READ_BUS;
  logic                  o_ALU_SUBTRACT;
  logic                  o_FLAGS_LATCH;
  logic                  o_HALT;

  logic                  o_PC_JUMP_n;
  logic                  o_MAR_READ_BUS_n;
  logic                  o_RAM_READ_BUS_n;
  logic                  o_RAM_WRITE_BUS_n;
  logic                  o_IR_READ_BUS_n;
  logic                  o_IR_WRITE_BUS_n;
  logic                  o_A_READ_BUS_n;
  logic                  o_A_WRITE_BUS_n;
  logic                  o_B_READ_BUS_n;
  logic                  o_ALU_WRITE_BUS_n;

  logic [2:0]            o_STEP;

  modport master (
    input  i_IR_DATA, i_CARRY, i_ZERO,
    output o_PC_WRITE_BUS, o_PC_COUNT_ENABLE, o_OUT_READ_BUS, o_ALU_SUBTRACT,
           o_FLAGS_LATCH, o_HALT, o_PC_JUMP_n, o_MAR_READ_BUS_n, o_RAM_READ_BUS_n,
           o_RAM_WRITE_BUS_n, o_IR_READ_BUS_n, o_IR_WRITE_BUS_n, o_A_READ_BUS_n,
           o_A_WRITE_BUS_n, o_B_READ_BUS_n, o_ALU_WRITE_BUS_n, o_STEP
  );

  modport slave (
    output i_IR_DATA, i_CARRY, i_ZERO,
    input  o_PC_WRITE_BUS, o_PC_COUNT_ENABLE, o_OUT_READ_BUS, o_ALU_SUBTRACT,
           o_FLAGS_LATCH, o_HALT, o_PC_JUMP_n, o_MAR_READ_BUS_n, o_RAM_READ_BUS_n,
           o_RAM_WRITE_BUS_n, o_IR_READ_BUS_n, o_IR_WRITE_BUS_n, o_A_READ_BUS_n,
           o_A_WRITE_BUS_n, o_B_READ_BUS_n, o_ALU_WRITE_BUS_n, o_STEP
  );
endinterface

// File: rtl/control_sequencer.sv
// Micro-step control sequencer for an 8-bit bus computer: fetch in T0/T1, execute in T2..T4.
// Define CONTROL_SEQUENCER_COND_JUMP_EN to enable JC/JZ; otherwise they execute as NOP.
module control_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input logic                  i_CLOCK,
  input logic                  i_CLEAR,
  control_sequencer_if.master  bus
);

  typedef enum logic [2:0] {T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4} step_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Controls held active-high internally; the _n outputs are inverted at the port.
  typedef struct packed {
    logic pc_out;
    logic pc_inc;
    logic pc_jump;
    logic out_in;
    logic alu_sub;
    logic flags_latch;
    logic mar_in;
    logic ram_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
  } ctrl_t;

  step_e      step_q, step_d;
  logic       halt_q, halt_d;
  logic       halt_set;
  logic       last_step;
  logic       active;
  logic [3:0] opcode;
  ctrl_t      ctrl;

  assign opcode = bus.i_IR_DATA[DATA_WIDTH-1 -: 4];
  assign active = !i_CLEAR && !halt_q;

  logic unused_ir;
  assign unused_ir = ^bus.i_IR_DATA[DATA_WIDTH-5:0];

`ifndef CONTROL_SEQUENCER_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = bus.i_CARRY ^ bus.i_ZERO;
`endif

  // Opcodes that have no execute phase finish after the fetch step T1.
  function automatic logic fetch_only(input logic [3:0] op);
    case (op)
      OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI, OP_JMP, OP_OUT, OP_HLT: fetch_only = 1'b0;
`ifdef CONTROL_SEQUENCER_COND_JUMP_EN
      OP_JC, OP_JZ: fetch_only = 1'b0;
`endif
      default: fetch_only = 1'b1;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    ctrl      = '0;
    last_step = 1'b0;
    halt_set  = 1'b0;
    case (step_q)
      T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
      end
      T1: begin
        ctrl.ram_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        ctrl.pc_inc  = 1'b1;
        last_step    = fetch_only(opcode);
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_out = 1'b1;
            ctrl.mar_in = 1'b1;
          end
          OP_LDI: begin
            ctrl.ir_out = 1'b1;
            ctrl.a_in   = 1'b1;
            last_step   = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_jump = 1'b1;
            last_step    = 1'b1;
          end
          OP_OUT: begin
            ctrl.a_out  = 1'b1;
            ctrl.out_in = 1'b1;
            last_step   = 1'b1;
          end
          OP_JC, OP_JZ: begin
`ifdef CONTROL_SEQUENCER_COND_JUMP_EN
            if ((opcode == OP_JC) ? bus.i_CARRY : bus.i_ZERO) begin
              ctrl.ir_out  = 1'b1;
              ctrl.pc_jump = 1'b1;
            end
`endif
            last_step = 1'b1;
          end
          OP_HLT: begin
            halt_set  = 1'b1;
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_out = 1'b1;
            ctrl.a_in    = 1'b1;
            last_step    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_out = 1'b1;
            ctrl.b_in    = 1'b1;
            ctrl.alu_sub = (opcode == OP_SUB);
          end
          OP_STA: begin
            ctrl.a_out  = 1'b1;
            ctrl.ram_in = 1'b1;
            last_step   = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        ctrl.alu_out     = (opcode == OP_ADD) || (opcode == OP_SUB);
        ctrl.a_in        = ctrl.alu_out;
        ctrl.flags_latch = ctrl.alu_out;
        ctrl.alu_sub     = (opcode == OP_SUB);
        last_step        = 1'b1;
      end
      default: last_step = 1'b1;
    endcase

    if (!active) begin
      ctrl     = '0;
      halt_set = 1'b0;
    end

    if (halt_q) begin
      step_d = T0;
    end else if (last_step) begin
      step_d = T0;
    end else begin
      step_d = step_e'(step_q + 3'd1);
    end
    halt_d = halt_q | halt_set;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_CLOCK) begin
    if (i_CLEAR) begin
      step_q <= T0;
      halt_q <= 1'b0;
    end else begin
      step_q <= step_d;
      halt_q <= halt_d;
    end
  end

  assign bus.o_PC_WRITE_BUS    = ctrl.pc_out;
  assign bus.o_PC_COUNT_ENABLE = ctrl.pc_inc;
  assign bus.o_OUT_READ_BUS    = ctrl.out_in;
  assign bus.o_ALU_SUBTRACT    = ctrl.alu_sub;
  assign bus.o_FLAGS_LATCH     = ctrl.flags_latch;
  assign bus.o_HALT            = halt_q && !i_CLEAR;

  assign bus.o_PC_JUMP_n       = !ctrl.pc_jump;
  assign bus.o_MAR_READ_BUS_n  = !ctrl.mar_in;
  assign bus.o_RAM_READ_BUS_n  = !ctrl.ram_in;
  assign bus.o_RAM_WRITE_BUS_n = !ctrl.ram_out;
  assign bus.o_IR_READ_BUS_n   = !ctrl.ir_in;
  assign bus.o_IR_WRITE_BUS_n  = !ctrl.ir_out;
  assign bus.o_A_READ_BUS_n    = !ctrl.a_in;
  assign bus.o_A_WRITE_BUS_n   = !ctrl.a_out;
  assign bus.o_B_READ_BUS_n    = !ctrl.b_in;
  assign bus.o_ALU_WRITE_BUS_n = !ctrl.alu_out;

  assign bus.o_STEP            = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-step control words compared against hand-built vectors.
// Control word bit order: PCW PCE OUT SUB FL HALT JMPn MARn RAMRn RAMWn IRRn IRWn ARn AWn BRn ALUWn.
module tb_control_sequencer;

  localparam logic [15:0] IDLE  = 16'h03FF;
  localparam logic [15:0] M_PCW = 16'h8000;
  localparam logic [15:0] M_PCE = 16'h4000;
  localparam logic [15:0] M_OUT = 16'h2000;
  localparam logic [15:0] M_SUB = 16'h1000;
  localparam logic [15:0] M_FL  = 16'h0800;
  localparam logic [15:0] M_HLT = 16'h0400;
  localparam logic [15:0] M_JMP = 16'h0200;
  localparam logic [15:0] M_MAR = 16'h0100;
  localparam logic [15:0] M_RMR = 16'h0080;
  localparam logic [15:0] M_RMW = 16'h0040;
  localparam logic [15:0] M_IRR = 16'h0020;
  localparam logic [15:0] M_IRW = 16'h0010;
  localparam logic [15:0] M_AR  = 16'h0008;
  localparam logic [15:0] M_AW  = 16'h0004;
  localparam logic [15:0] M_BR  = 16'h0002;
  localparam logic [15:0] M_ALW = 16'h0001;

  // Hand-derived words: T0 = 16'h82FF, T1 = 16'h439F
  localparam logic [15:0] W_T0  = IDLE ^ (M_PCW | M_MAR);
  localparam logic [15:0] W_T1  = IDLE ^ (M_RMW | M_IRR | M_PCE);
  localparam logic [15:0] W_ADR = IDLE ^ (M_IRW | M_MAR);          // 16'h02EF
  localparam logic [15:0] W_JMP = IDLE ^ (M_IRW | M_JMP);          // 16'h01EF

  logic clk;
  logic clr;
  int   n_total;
  int   n_bad;
  logic [15:0] exp_v [5];

  control_sequencer_if #(.DATA_WIDTH(8)) bus ();

  control_sequencer #(.DATA_WIDTH(8)) dut (
    .i_CLOCK (clk),
    .i_CLEAR (clr),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] obs_ctrl;
  assign obs_ctrl = {bus.o_PC_WRITE_BUS, bus.o_PC_COUNT_ENABLE, bus.o_OUT_READ_BUS,
                     bus.o_ALU_SUBTRACT, bus.o_FLAGS_LATCH, bus.o_HALT, bus.o_PC_JUMP_n,
                     bus.o_MAR_READ_BUS_n, bus.o_RAM_READ_BUS_n, bus.o_RAM_WRITE_BUS_n,
                     bus.o_IR_READ_BUS_n, bus.o_IR_WRITE_BUS_n, bus.o_A_READ_BUS_n,
                     bus.o_A_WRITE_BUS_n, bus.o_B_READ_BUS_n, bus.o_ALU_WRITE_BUS_n};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_one_driver(input string tag);
    int n_drv;
    n_drv = int'(bus.o_PC_WRITE_BUS) + int'(!bus.o_RAM_WRITE_BUS_n) + int'(!bus.o_IR_WRITE_BUS_n)
          + int'(!bus.o_A_WRITE_BUS_n) + int'(!bus.o_ALU_WRITE_BUS_n);
    check($sformatf("%s_one_driver", tag), 32'(n_drv <= 1), 32'd1);
  endtask

  // Runs one instruction of n steps, checking step, control word and bus ownership each cycle.
  task automatic run_instr(input string tag, input logic [7:0] ir, input int n);
    bus.i_IR_DATA = ir;
    #1;
    for (int s = 0; s < n; s++) begin
      check($sformatf("%s_step%0d", tag, s), 32'(bus.o_STEP), 32'(s));
      check($sformatf("%s_ctrl_t%0d", tag, s), 32'(obs_ctrl), 32'(exp_v[s]));
      check_one_driver($sformatf("%s_t%0d", tag, s));
      tick();
    end
    check($sformatf("%s_wrap", tag), 32'(bus.o_STEP), 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clr           = 1'b1;
    bus.i_IR_DATA = 8'h00;
    bus.i_CARRY   = 1'b0;
    bus.i_ZERO    = 1'b0;
    tick();
    check("clear_ctrl", 32'(obs_ctrl), 32'(IDLE));
    check("clear_step", 32'(bus.o_STEP), 32'd0);
    tick();
    clr = 1'b0;
    #1;

    exp_v = '{W_T0, W_T1, W_ADR, IDLE ^ (M_RMW | M_AR), IDLE};
    run_instr("lda", 8'h1E, 4);

    exp_v = '{W_T0, W_T1, W_ADR, IDLE ^ (M_RMW | M_BR), IDLE ^ (M_ALW | M_AR | M_FL)};
    run_instr("add", 8'h25, 5);

    exp_v = '{W_T0, W_T1, W_ADR, IDLE ^ (M_RMW | M_BR | M_SUB),
              IDLE ^ (M_ALW | M_AR | M_FL | M_SUB)};
    run_instr("sub", 8'h3F, 5);

    exp_v = '{W_T0, W_T1, W_ADR, IDLE ^ (M_AW | M_RMR), IDLE};
    run_instr("sta", 8'h4D, 4);

    exp_v = '{W_T0, W_T1, IDLE ^ (M_IRW | M_AR), IDLE, IDLE};
    run_instr("ldi", 8'h57, 3);

    exp_v = '{W_T0, W_T1, W_JMP, IDLE, IDLE};
    run_instr("jmp", 8'h62, 3);

    exp_v = '{W_T0, W_T1, IDLE ^ (M_AW | M_OUT), IDLE, IDLE};
    run_instr("out", 8'hE0, 3);

    exp_v = '{W_T0, W_T1, IDLE, IDLE, IDLE};
    run_instr("nop", 8'h00, 2);
    for (int op = 9; op <= 13; op++) begin
      run_instr($sformatf("undef%0d", op), {4'(op), 4'h3}, 2);
    end

`ifdef CONTROL_SEQUENCER_COND_JUMP_EN
    bus.i_CARRY = 1'b0;
    exp_v = '{W_T0, W_T1, IDLE, IDLE, IDLE};
    run_instr("jc_nc", 8'h73, 3);
    bus.i_CARRY = 1'b1;
    exp_v = '{W_T0, W_T1, W_JMP, IDLE, IDLE};
    run_instr("jc_c", 8'h73, 3);
    bus.i_CARRY = 1'b0;
    bus.i_ZERO  = 1'b0;
    exp_v = '{W_T0, W_T1, IDLE, IDLE, IDLE};
    run_instr("jz_nz", 8'h84, 3);
    bus.i_ZERO  = 1'b1;
    exp_v = '{W_T0, W_T1, W_JMP, IDLE, IDLE};
    run_instr("jz_z", 8'h84, 3);
`else
    exp_v = '{W_T0, W_T1, IDLE, IDLE, IDLE};
    bus.i_CARRY = 1'b0;
    run_instr("jc_nc", 8'h73, 2);
    bus.i_CARRY = 1'b1;
    run_instr("jc_c", 8'h73, 2);
    bus.i_ZERO  = 1'b1;
    run_instr("jz_z", 8'h84, 2);
`endif
    bus.i_CARRY = 1'b0;
    bus.i_ZERO  = 1'b0;

    // Halt: T2 itself is quiet, then HALT stays up with the step pinned at 0.
    exp_v = '{W_T0, W_T1, IDLE, IDLE, IDLE};
    run_instr("hlt", 8'hF0, 3);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("halted_ctrl%0d", c), 32'(obs_ctrl), 32'(IDLE | M_HLT));
      check($sformatf("halted_step%0d", c), 32'(bus.o_STEP), 32'd0);
      tick();
    end
    clr = 1'b1;
    #1;
    check("halt_clear_ctrl", 32'(obs_ctrl), 32'(IDLE));
    tick();
    clr = 1'b0;
    #1;
    check("halt_release_step", 32'(bus.o_STEP), 32'd0);
    check("halt_release_ctrl", 32'(obs_ctrl), 32'(W_T0));

    // Abort an ADD at T3 with a one-cycle clear.
    bus.i_IR_DATA = 8'h25;
    tick();
    tick();
    tick();
    check("abort_at_t3", 32'(bus.o_STEP), 32'd3);
    clr = 1'b1;
    #1;
    check("abort_clear_ctrl", 32'(obs_ctrl), 32'(IDLE));
    tick();
    clr = 1'b0;
    #1;
    check("abort_step", 32'(bus.o_STEP), 32'd0);
    check("abort_pc_write", 32'(bus.o_PC_WRITE_BUS), 32'd1);

    exp_v = '{W_T0, W_T1, IDLE ^ (M_IRW | M_AR), IDLE, IDLE};
    run_instr("ldi_after", 8'h51, 3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the IR/bus width; opcode is IR bits [DATA_WIDTH-1:DATA_WIDTH-4].
REQ-002 SHALL have i_CLOCK  input  1  single clock; all state updates on rising edge; top level drives it from CLOCK_n.
REQ-003 SHALL have i_CLEAR  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have i_IR_DATA  input  DATA_WIDTH  instruction register contents.
REQ-005 SHALL have i_CARRY, i_ZERO  input  1 each  ALU flag register outputs.
REQ-006 SHALL have o_PC_WRITE_BUS, o_PC_COUNT_ENABLE, o_OUT_READ_BUS, o_ALU_SUBTRACT, o_FLAGS_LATCH, o_HALT  output  1 each  active-high controls.
REQ-007 SHALL have o_PC_JUMP_n, o_MAR_READ_BUS_n, o_RAM_READ_BUS_n, o_RAM_WRITE_BUS_n, o_IR_READ_BUS_n, o_IR_WRITE_BUS_n, o_A_READ_BUS_n, o_A_WRITE_BUS_n, o_B_READ_BUS_n, o_ALU_WRITE_BUS_n  output  1 each  active-low controls (READ = load from bus, WRITE = drive bus).
REQ-008 SHALL have o_STEP  output  3  current micro-step T0..T4.

Function
REQ-009 SHALL hold a 3-bit step counter; controls are combinational from step, opcode and flags.
REQ-010 SHALL assert at most one bus driver (PC_WRITE_BUS, RAM/IR/A/ALU_WRITE_BUS_n) in any step.
REQ-011 T0 SHALL assert PC_WRITE_BUS, MAR_READ_BUS_n; T1 SHALL assert RAM_WRITE_BUS_n, IR_READ_BUS_n, PC_COUNT_ENABLE, for every opcode.
REQ-012 LDA 0001: T2 IR_WRITE+MAR_READ; T3 RAM_WRITE+A_READ; then T0.
REQ-013 ADD 0010 / SUB 0011: T2 IR_WRITE+MAR_READ; T3 RAM_WRITE+B_READ; T4 ALU_WRITE+A_READ+FLAGS_LATCH; SUB also asserts ALU_SUBTRACT in T3 and T4.
REQ-014 STA 0100: T2 IR_WRITE+MAR_READ; T3 A_WRITE+RAM_READ.
REQ-015 LDI 0101: T2 IR_WRITE+A_READ. JMP 0110: T2 IR_WRITE+PC_JUMP_n. OUT 1110: T2 A_WRITE+OUT_READ_BUS.
REQ-016 JC 0111 / JZ 1000: T2 IR_WRITE+PC_JUMP_n only if i_CARRY / i_ZERO is 1 at T2; otherwise T2 idle; always 3 steps.
REQ-017 NOP 0000 and undefined opcodes 1001-1101 SHALL end after T1 (2 steps), no controls beyond fetch.
REQ-018 After the last step of an instruction the counter SHALL return to T0 on the next edge; no dead cycles; T4 always wraps to T0.
REQ-019 HLT 1111: T2 SHALL set a halt flag; thereafter o_HALT=1, step held at 0, all controls inactive until i_CLEAR.
REQ-020 Inactive levels: active-high outputs 0, active-low outputs 1.

Reset
REQ-021 While i_CLEAR=1 all controls SHALL be inactive and o_HALT=0; on the edge step SHALL become 0 and halt flag 0.
REQ-022 i_CLEAR mid-instruction or while halted SHALL abort it; first cycle after release is T0 fetch.
REQ-023 i_CLEAR SHALL take priority over halt and step advance on the same edge.

Configuration
REQ-024 With CONTROL_SEQUENCER_COND_JUMP_EN defined, JC/JZ SHALL behave per REQ-016.
REQ-025 Without it, 0111/1000 SHALL behave as NOP (REQ-017) and i_CARRY/i_ZERO SHALL be unused.

Verification
REQ-026 Clear then IR=0x1E (LDA 14): steps T0..T3, T3 RAM_WRITE_BUS_n=0, A_READ_BUS_n=0, next step 0.
REQ-027 IR=0x3F (SUB): T4 ALU_WRITE_BUS_n=0, A_READ_BUS_n=0, ALU_SUBTRACT=1, FLAGS_LATCH=1; 5-cycle instruction.
REQ-028 IR=0x73, i_CARRY=0 then 1 (macro defined): PC_JUMP_n=1 then 0 at T2; macro undefined: 2-cycle NOP both cases.
REQ-029 IR=0xF0: o_HALT=1 after T2, step stuck at 0, controls inactive 10 cycles; i_CLEAR releases to T0.
REQ-030 i_CLEAR at T3 of ADD: next cycle T0, PC_WRITE_BUS=1; every cycle of all opcodes checked for single bus driver.
